// File: rtl/instr_fetch_buffer.sv
// Prefetch FIFO: flop storage, head driven from the rd_ptr entry; flush clears occupancy.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: push honoured only when not full or popping in the same cycle.
module ifb_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic                       head_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop_rdy & (count_q != '0);
    assign push_ok = push_vld & ((count_q != CW'(DEPTH)) | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity comes solely from count_q.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_vld = (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// Fetch stage: drives RAM word address from the byte PC and queues {pc, word} for decode.
// Latency: fetched word reaches decode one cycle after the fetching edge; 1 instr/cycle sustained.
// Backpressure: instr_ready low holds the head; fetching stalls when the queue is full.
module instr_fetch_buffer #(
    parameter int          DEPTH      = 4,
    parameter int          ADDR_WIDTH = 7,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [31:0]                mem_data,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_ent_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pop, push, full;
    fetch_ent_t  push_dat, head_dat;

    assign full     = (buf_count == CW'(DEPTH));
    assign pop      = instr_valid & instr_ready;
    assign push     = fetch_en & ~redirect & (~full | pop);
    assign mem_addr = fetch_pc_q[ADDR_WIDTH+1:2];
    assign push_dat = '{pc: fetch_pc_q, word: mem_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect)  fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        else if (push) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    // A pop coinciding with redirect still counts as consumed; the flush then empties the rest.
    ifb_fifo #(.WIDTH($bits(fetch_ent_t)), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_rdy  (pop),
        .head_vld (instr_valid),
        .head_dat (head_dat),
        .count    (buf_count)
    );

    assign instr    = head_dat.word;
    assign instr_pc = head_dat.pc;
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: RAM model plus a reference queue model checked from scenario tasks.
module tb_instr_fetch_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic [6:0]  mem_addr;
    logic [31:0] mem_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [2:0]  buf_count;

    logic [31:0] ram [128];
    logic [63:0] exp_q [$];
    logic [31:0] m_pc = 32'h0;
    logic        m_pop, m_push;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clock = ~clock;
    assign mem_data = ram[mem_addr];

    instr_fetch_buffer #(.DEPTH(4), .ADDR_WIDTH(7), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .buf_count   (buf_count)
    );

    // Reference model: expected queue contents, pushed when a fetch should occur.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_pc = 32'h0;
        end else begin
            m_pop  = (exp_q.size() != 0) && instr_ready;
            m_push = fetch_en && !redirect && ((exp_q.size() < 4) || m_pop);
            if (m_pop) void'(exp_q.pop_front());
            if (redirect) begin
                exp_q.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (m_push) begin
                exp_q.push_back({m_pc, ram[m_pc[8:2]]});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (instr_valid !== 1'b0 || buf_count !== 3'd0 || mem_addr !== 7'd0) begin
            n_err++;
            $display("FAIL reset: valid=%b count=%0d addr=%0d, want 0/0/0", instr_valid, buf_count, mem_addr);
        end
        do_reset();
        n_vec++;
        if (instr_valid !== 1'b0 || buf_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_release: valid=%b count=%0d, want 0/0", instr_valid, buf_count);
        end
    endtask

    task automatic test_stream();
        logic [31:0] tab [4];
        tab[0] = 32'h0; tab[1] = 32'h0; tab[2] = 32'h200b0003; tab[3] = 32'h200b0000;
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n_vec++;
            if (instr_valid !== (exp_q.size() != 0) || buf_count !== exp_q.size() || buf_count > 3'd1) begin
                n_err++;
                $display("FAIL stream_occ c%0d: valid=%b count=%0d, want valid=%b count=%0d", i, instr_valid, buf_count, exp_q.size() != 0, exp_q.size());
            end
            if (instr_valid === 1'b1 && exp_q.size() != 0) begin
                n_vec++;
                if ({instr_pc, instr} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL stream_sb c%0d: got %h/%h, want %h", i, instr_pc, instr, exp_q[0]);
                end
            end
            if (i < 4) begin
                n_vec++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr !== tab[i]) begin
                    n_err++;
                    $display("FAIL stream_seq c%0d: v=%b pc=%h instr=%h, want 1/%h/%h", i, instr_valid, instr_pc, instr, 32'(i * 4), tab[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want_pc;
        int          pops;
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (10) @(negedge clock);
        n_vec++;
        if (buf_count !== 3'd4 || mem_addr !== 7'd4 || instr_pc !== 32'h0) begin
            n_err++;
            $display("FAIL bp_full: count=%0d addr=%0d head=%h, want 4/4/0", buf_count, mem_addr, instr_pc);
        end
        instr_ready = 1'b1;
        want_pc = 32'h0;
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (instr_valid !== (exp_q.size() != 0) || buf_count !== exp_q.size()) begin
                n_err++;
                $display("FAIL bp_occ c%0d: valid=%b count=%0d, want valid=%b count=%0d", i, instr_valid, buf_count, exp_q.size() != 0, exp_q.size());
            end
            if (instr_valid === 1'b1) begin
                n_vec++;
                if (instr_pc !== want_pc || instr !== ram[want_pc[8:2]]) begin
                    n_err++;
                    $display("FAIL bp_order c%0d: pc=%h instr=%h, want %h/%h", i, instr_pc, instr, want_pc, ram[want_pc[8:2]]);
                end
                want_pc = want_pc + 32'd4;
                pops++;
            end
            @(negedge clock);
        end
        n_vec++;
        if (pops != 12) begin
            n_err++;
            $display("FAIL bp_rate: got %0d deliveries in 12 cycles, want 12", pops);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (6) @(negedge clock);
        redirect = 1'b1; redirect_pc = 32'h20; instr_ready = 1'b1;
        @(negedge clock);
        redirect = 1'b0;
        n_vec++;
        if (instr_valid !== 1'b0 || buf_count !== 3'd0 || mem_addr !== 7'd8) begin
            n_err++;
            $display("FAIL redir_flush: valid=%b count=%0d addr=%0d, want 0/0/8", instr_valid, buf_count, mem_addr);
        end
        @(negedge clock);
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== 32'h2008000a) begin
            n_err++;
            $display("FAIL redir_target: v=%b pc=%h instr=%h, want 1/00000020/2008000a", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'h1FE; instr_ready = 1'b0; fetch_en = 1'b1;
        @(negedge clock);
        redirect = 1'b0;
        n_vec++;
        if (mem_addr !== 7'd127 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_addr: addr=%0d valid=%b, want 127/0", mem_addr, instr_valid);
        end
        @(negedge clock);
        n_vec++;
        if (mem_addr !== 7'd0 || instr_pc !== 32'h1FC || instr !== ram[127]) begin
            n_err++;
            $display("FAIL wrap_first: addr=%0d pc=%h instr=%h, want 0/000001fc/%h", mem_addr, instr_pc, instr, ram[127]);
        end
        instr_ready = 1'b1;
        @(negedge clock);
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== ram[0]) begin
            n_err++;
            $display("FAIL wrap_pc: v=%b pc=%h instr=%h, want 1/00000200/%h", instr_valid, instr_pc, instr, ram[0]);
        end
    endtask

    task automatic test_drain();
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (3) @(negedge clock);
        fetch_en = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (buf_count !== exp_q.size() || instr_valid !== (exp_q.size() != 0) || mem_addr !== 7'd3) begin
                n_err++;
                $display("FAIL drain c%0d: count=%0d valid=%b addr=%0d, want %0d/%b/3", i, buf_count, instr_valid, mem_addr, exp_q.size(), exp_q.size() != 0);
            end
            if (instr_valid === 1'b1 && exp_q.size() != 0) begin
                n_vec++;
                if ({instr_pc, instr} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL drain_sb c%0d: got %h/%h, want %h", i, instr_pc, instr, exp_q[0]);
                end
            end
            @(negedge clock);
        end
        fetch_en = 1'b1;
        @(negedge clock);
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== 32'h200b0000) begin
            n_err++;
            $display("FAIL drain_resume: v=%b pc=%h instr=%h, want 1/0000000c/200b0000", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        repeat (3) @(negedge clock);
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clock);
        redirect_pc = 32'h83;
        @(negedge clock);
        redirect = 1'b0;
        n_vec++;
        if (instr_valid !== 1'b0 || mem_addr !== 7'd32) begin
            n_err++;
            $display("FAIL b2b_flush: valid=%b addr=%0d, want 0/32", instr_valid, mem_addr);
        end
        @(negedge clock);
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h80 || instr !== ram[32]) begin
            n_err++;
            $display("FAIL b2b_target: v=%b pc=%h instr=%h, want 1/00000080/%h", instr_valid, instr_pc, instr, ram[32]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if (buf_count !== 3'd3) begin
            n_err++;
            $display("FAIL arst_pre: count=%0d, want 3", buf_count);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (instr_valid !== 1'b0 || buf_count !== 3'd0 || mem_addr !== 7'd0) begin
            n_err++;
            $display("FAIL arst_now: valid=%b count=%0d addr=%0d, want 0/0/0", instr_valid, buf_count, mem_addr);
        end
        @(negedge clock);
        reset = 1'b1; instr_ready = 1'b1;
        @(negedge clock);
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin
            n_err++;
            $display("FAIL arst_restart: v=%b pc=%h instr=%h, want 1/0/0", instr_valid, instr_pc, instr);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'hA500_0000 | 32'(i);
        ram[0] = 32'h0;
        ram[1] = 32'h0;
        ram[2] = 32'h200b0003;
        ram[3] = 32'h200b0000;
        ram[8] = 32'h2008000a;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_drain();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Instruction fetch stage that sits directly downstream of the 128x32 word RAM.
- Drives the RAM read address from a byte program counter and captures the combinational read data.
- Queues fetched words with their PCs in a small prefetch FIFO.
- Presents the FIFO head to decode through a valid/ready handshake; a redirect input (branch/jump) flushes the queue and reloads the PC.

Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 7: RAM word-address width (128 words).
- RESET_PC, 32'h00000000: byte PC loaded on reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  1: fetching allowed; 0: freeze PC, no pushes (RAM being loaded/written).
- mem_addr  out  ADDR_WIDTH  RAM word address = fetch_pc[ADDR_WIDTH+1:2]; combinational from fetch_pc.
- mem_data  in  32  RAM read data for mem_addr, same cycle.
- redirect  in  1  1: flush queue, load redirect_pc.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored (forced to 0).
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction word.
- instr_pc  out  32  byte PC of head instruction.
- instr_ready  in  1  decode accepts head this cycle.
- buf_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, rd/wr pointers 0, buf_count=0, instr_valid=0. instr and instr_pc are don't-care; bench checks them only when instr_valid=1.
- pop = instr_valid & instr_ready.
- push = fetch_en & ~redirect & (buf_count<DEPTH | pop). Push while full is legal only when a pop occurs in the same cycle.
- On push at the clock edge: write {fetch_pc, mem_data} at wr_ptr; fetch_pc += 4 (full 32-bit add).
- Address wrap: mem_addr wraps 127→0 naturally as fetch_pc crosses 0x200 multiples. instr_pc keeps the full 32-bit value.
- buf_count update: +1 on push only, −1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Head outputs are a registered FIFO read: instr/instr_pc/instr_valid reflect the entry at rd_ptr.
- Latency: first instr_valid=1 on the cycle after the first rising edge with fetch_en=1 following reset release, carrying instr_pc=RESET_PC.
- Sustained throughput is 1 instr/cycle with instr_ready=1.
- Redirect has priority over push:
  - A pop in the redirect cycle still completes; decode consumed that entry.
  - At the edge, the FIFO is cleared (buf_count=0, pointers reset) and fetch_pc = {redirect_pc[31:2],2'b00}.
  - Next cycle instr_valid=0. The following edge pushes the target word if fetch_en=1.
  - Redirect with fetch_en=0 still flushes and loads the PC.
- fetch_en=0: no pushes, fetch_pc held; pops continue and drain the queue.
- instr_ready=0 with instr_valid=1: head outputs held stable until accepted or redirected.
- Back-to-back redirects: each one reloads the PC; the last one wins.
- RAM writes by the stage owning the RAM are not snooped. Words already queued stay stale; software/controller must redirect after self-modifying writes.

Test Plan:
- Release reset with RAM instruction-preloaded, fetch_en=1, instr_ready=1 → instr_valid rises one cycle after the first edge; sequence (pc,instr) = (0x0,0x00000000),(0x4,0x00000000),(0x8,0x200b0003),(0xC,0x200b0000), one per cycle, buf_count ≤1.
- Backpressure: instr_ready=0 for 10 cycles after reset → buf_count saturates at 4, fetch_pc=0x10, mem_addr=4. Then instr_ready=1 → pcs 0x0,0x4,0x8,0xC,0x10… delivered in order with no loss or duplication.
- Redirect to 0x20 while full, instr_ready=1 in the same cycle → head at that cycle counts as consumed. Next cycle instr_valid=0; the cycle after that, instr_pc=0x20, instr=0x2008000a.
- Wrap: redirect_pc=0x1FE → fetch_pc=0x1FC, mem_addr=127. The next fetch has instr_pc=0x200 and mem_addr=0.
- fetch_en=0 with 3 entries queued and instr_ready=1 → 3 instructions drain, then instr_valid=0, mem_addr frozen. fetch_en=1 resumes from the held PC.
- Assert reset mid-stream with buf_count=3 → instr_valid and buf_count go to 0 immediately, before the next clock edge. After release, fetching restarts at RESET_PC.
